// File: rtl/mac_scheduler_if.sv
// +--------------------------------------------------------------------------+
// | mac_scheduler_if : requester, mac and result bundle of the mac scheduler |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mac_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*ADDR_LINES-1:0] req_terms_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_signal_i;
  logic [NUM_REQ-1:0]            req_empty_i;
  logic [NUM_REQ-1:0]            req_rd_o;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [DATA_WIDTH-1:0]         mac_signal_o;
  logic                          mac_empty_o;
  logic                          mac_rd_i;
  logic                          mac_start_o;
  logic [ADDR_LINES-1:0]         mac_terms_o;
  logic [DATA_WIDTH-1:0]         mac_result_i;
  logic                          mac_done_i;
  logic                          mac_flush_o;
  logic [DATA_WIDTH-1:0]         result_o;
  logic [NUM_REQ-1:0]            result_valid_o;
  logic                          result_err_o;
  logic                          busy_o;

  modport slave (
    input  req_i, req_terms_i, req_signal_i, req_empty_i, mac_rd_i, mac_result_i, mac_done_i,
    output req_rd_o, gnt_o, mac_signal_o, mac_empty_o, mac_start_o, mac_terms_o, mac_flush_o,
           result_o, result_valid_o, result_err_o, busy_o
  );

  modport master (
    output req_i, req_terms_i, req_signal_i, req_empty_i, mac_rd_i, mac_result_i, mac_done_i,
    input  req_rd_o, gnt_o, mac_signal_o, mac_empty_o, mac_start_o, mac_terms_o, mac_flush_o,
           result_o, result_valid_o, result_err_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/mac_scheduler.sv
// +--------------------------------------------------------------------------+
// | mac_scheduler : round-robin sharing of one mac among NUM_REQ requesters  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mac_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5,
  parameter int TIMEOUT    = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mac_scheduler_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_DELIVER = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_last;
  logic [IDX_W-1:0]      r_winner;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_flush_ph;
  logic                  r_abandon;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_start;
  logic [ADDR_LINES-1:0] r_terms;
  logic                  r_flush;
  logic [DATA_WIDTH-1:0] r_result;
  logic [NUM_REQ-1:0]    r_valid;
  logic                  r_err;

  logic                  w_any;
  logic [IDX_W-1:0]      w_pick;
  logic [IDX_W-1:0]      w_cand;
  logic                  w_active;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    f_onehot      = '0;
    f_onehot[idx] = 1'b1;
  endfunction

  // First requesting index found scanning upward from the slot after the last winner.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_last) + i) % NUM_REQ);
      if (!w_any && bus.req_i[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_last     <= IDX_W'(NUM_REQ - 1);
      r_winner   <= '0;
      r_cnt      <= '0;
      r_flush_ph <= 1'b0;
      r_gnt      <= '0;
      r_start    <= 1'b0;
      r_terms    <= '0;
      r_flush    <= 1'b0;
      r_result   <= '0;
      r_valid    <= '0;
      r_err      <= 1'b0;
      r_abandon  <= r_abandon | (r_state != S_IDLE);
    end else begin
      r_abandon <= 1'b0;
      r_gnt     <= '0;
      r_start   <= 1'b0;
      r_terms   <= '0;
      r_valid   <= '0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt    <= f_onehot(w_pick);
            r_winner <= w_pick;
            r_last   <= w_pick;
            r_start  <= 1'b1;
            r_terms  <= bus.req_terms_i[w_pick*ADDR_LINES +: ADDR_LINES];
            r_cnt    <= '0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (bus.mac_done_i) begin
            r_result <= bus.mac_result_i;
            r_valid  <= f_onehot(r_winner);
            r_state  <= S_DELIVER;
          end else if (r_cnt == c_cnt_last) begin
            r_flush    <= 1'b1;
            r_flush_ph <= 1'b0;
            r_state    <= S_FLUSH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DELIVER: r_state <= S_IDLE;
        S_FLUSH: begin
          if (!r_flush_ph) begin
            r_flush_ph <= 1'b1;
            r_valid    <= f_onehot(r_winner);
            r_err      <= 1'b1;
            r_result   <= '0;
          end else begin
            r_flush_ph <= 1'b0;
            r_flush    <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_active = (r_state == S_START) || (r_state == S_RUN);

  assign bus.gnt_o          = r_gnt;
  assign bus.mac_start_o    = r_start;
  assign bus.mac_terms_o    = r_terms;
  // A job cut short by reset gets one cleanup flush once reset is released.
  assign bus.mac_flush_o    = r_flush | (r_abandon & ~rst_i);
  assign bus.result_o       = r_result;
  assign bus.result_valid_o = r_valid;
  assign bus.result_err_o   = r_err;
  assign bus.busy_o         = (r_state != S_IDLE);
  assign bus.mac_signal_o   = w_active ? bus.req_signal_i[r_winner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.mac_empty_o    = w_active ? bus.req_empty_i[r_winner] : 1'b1;
  assign bus.req_rd_o       = (w_active && bus.mac_rd_i) ? f_onehot(r_winner) : '0;

endmodule

`default_nettype wire

// File: tb/tb_mac_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_mac_scheduler : scoreboard bench for mac_scheduler                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mac_scheduler;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AL = 5;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_LINES(AL)) bus ();

  mac_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_LINES(AL), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [NR-1:0] valid;
    logic [DW-1:0] res;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [NR-1:0] gnt_q[$];
  logic [AL-1:0] terms_q[$];

  int n_total = 0;
  int n_bad   = 0;
  int n_starts = 0;
  int flush_cycles = 0;
  int lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mac model: done arrives mdl_delay cycles after the start pulse; 0 means never.
  int            mdl_delay  = 0;
  int            rem        = -1;
  logic [DW-1:0] mdl_result = '0;
  logic          mdl_done   = 1'b0;
  logic          stray_done = 1'b0;

  assign bus.mac_done_i   = mdl_done | stray_done;
  assign bus.mac_result_i = mdl_result;

  always @(negedge clk) begin
    mdl_done = 1'b0;
    if (rst) rem = -1;
    else if (bus.mac_start_o) rem = (mdl_delay > 0) ? mdl_delay : -1;
    else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        mdl_done = 1'b1;
        rem = -1;
      end
    end
  end

  exp_t          m_e;
  logic [NR-1:0] m_g;
  logic [AL-1:0] m_t;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mac_flush_o) flush_cycles++;
      if (bus.gnt_o != '0) begin
        if (gnt_q.size() == 0) chk("gnt_unexp", bus.gnt_o, 0);
        else begin
          m_g = gnt_q.pop_front();
          chk("gnt", bus.gnt_o, m_g);
          chk("gnt_with_start", bus.mac_start_o, 1);
        end
      end
      if (bus.mac_start_o) begin
        n_starts++;
        if (terms_q.size() == 0) chk("start_unexp", bus.mac_start_o, 0);
        else begin
          m_t = terms_q.pop_front();
          chk("terms", bus.mac_terms_o, m_t);
        end
      end
      if (bus.result_valid_o != '0) begin
        if (exp_q.size() == 0) chk("valid_unexp", bus.result_valid_o, 0);
        else begin
          m_e = exp_q.pop_front();
          chk("res_valid", bus.result_valid_o, m_e.valid);
          chk("res_data", bus.result_o, m_e.res);
          chk("res_err", bus.result_err_o, m_e.err);
          chk("res_flush_align", bus.mac_flush_o, m_e.err);
        end
      end
    end
  end

  task automatic push_job(input logic [NR-1:0] g, input logic [AL-1:0] t,
                          input logic [DW-1:0] r, input logic e);
    exp_t x;
    x.valid = g;
    x.res   = r;
    x.err   = e;
    gnt_q.push_back(g);
    terms_q.push_back(t);
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int max);
    int k;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (bus.gnt_o != '0) break;
      k++;
      if (k >= max) begin
        chk("gnt_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.result_valid_o != '0) break;
      if (n >= max) begin
        chk("valid_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (!bus.busy_o) break;
      k++;
      if (k >= max) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic chk_reset();
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_rd", bus.req_rd_o, 0);
    chk("rst_valid", bus.result_valid_o, 0);
    chk("rst_start", bus.mac_start_o, 0);
    chk("rst_flush", bus.mac_flush_o, 0);
    chk("rst_err", bus.result_err_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_terms", bus.mac_terms_o, 0);
    chk("rst_empty", bus.mac_empty_o, 1);
    chk("rst_result", bus.result_o, 0);
  endtask

  initial begin
    bus.req_i        = '0;
    bus.req_terms_i  = '0;
    bus.req_signal_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.req_empty_i  = '0;
    bus.mac_rd_i     = 1'b0;
    for (int k = 0; k < NR; k++) bus.req_terms_i[k*AL +: AL] = AL'(k + 1);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    tick();
    rst = 1'b0;

    // Four requesters held high: strict rotation starting at 0
    mdl_delay  = 5;
    mdl_result = 32'h0000_0055;
    push_job(4'b0001, 5'd1, 32'h55, 1'b0);
    push_job(4'b0010, 5'd2, 32'h55, 1'b0);
    push_job(4'b0100, 5'd3, 32'h55, 1'b0);
    push_job(4'b1000, 5'd4, 32'h55, 1'b0);
    push_job(4'b0001, 5'd1, 32'h55, 1'b0);
    bus.req_i = 4'b1111;
    repeat (5) wait_gnt(100);
    bus.req_i = '0;
    wait_idle(100);
    chk("rr_drained", exp_q.size() + gnt_q.size() + terms_q.size(), 0);

    // Single job, 20-cycle mac
    bus.req_terms_i[0*AL +: AL] = 5'd3;
    mdl_delay  = 20;
    mdl_result = 32'h3F80_0000;
    flush_cycles = 0;
    n_starts = 0;
    push_job(4'b0001, 5'd3, 32'h3F80_0000, 1'b0);
    bus.req_i = 4'b0001;
    wait_gnt(100);
    bus.req_i = '0;
    wait_valid(100, lat);
    chk("single_latency", lat, 21);
    wait_idle(100);
    chk("single_starts", n_starts, 1);
    chk("single_no_flush", flush_cycles, 0);

    // Requester 1: read strobe and data routing during RUN
    bus.req_terms_i[1*AL +: AL] = 5'd7;
    mdl_delay  = 30;
    mdl_result = 32'h0000_1234;
    push_job(4'b0010, 5'd7, 32'h0000_1234, 1'b0);
    bus.req_i = 4'b0010;
    wait_gnt(100);
    bus.req_i = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.mac_rd_i = i[0];
      bus.req_signal_i[1*DW +: DW] = 32'hBEEF_0000 + DW'(i);
      bus.req_empty_i = {2'b00, i[1], 1'b0};
      @(negedge clk);
      chk("run_rd", bus.req_rd_o, i[0] ? 4'b0010 : 4'b0000);
      chk("run_signal", bus.mac_signal_o, 32'hBEEF_0000 + DW'(i));
      chk("run_empty", bus.mac_empty_o, i[1]);
    end
    tick();
    bus.mac_rd_i = 1'b0;
    bus.req_empty_i = '0;
    wait_idle(100);
    // Stray done and read strobe while idle
    tick();
    stray_done   = 1'b1;
    bus.mac_rd_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_busy", bus.busy_o, 0);
      chk("stray_valid", bus.result_valid_o, 0);
      chk("idle_signal", bus.mac_signal_o, 0);
      chk("idle_empty", bus.mac_empty_o, 1);
      chk("idle_rd", bus.req_rd_o, 0);
    end
    tick();
    stray_done   = 1'b0;
    bus.mac_rd_i = 1'b0;

    // Requester 2, mac never finishes: timeout flush with error
    bus.req_terms_i[2*AL +: AL] = 5'd9;
    mdl_delay  = 0;
    mdl_result = 32'hDEAD_DEAD;
    flush_cycles = 0;
    push_job(4'b0100, 5'd9, 32'h0, 1'b1);
    bus.req_i = 4'b0100;
    wait_gnt(100);
    bus.req_i = '0;
    wait_valid(TO + 100, lat);
    chk("timeout_latency", lat, TO + 2);
    wait_idle(100);
    chk("timeout_flush_cycles", flush_cycles, 2);

    // Requester 3, done coincides with the last counted cycle
    bus.req_terms_i[3*AL +: AL] = 5'd31;
    mdl_delay  = TO;
    mdl_result = 32'h0BAD_F00D;
    flush_cycles = 0;
    push_job(4'b1000, 5'd31, 32'h0BAD_F00D, 1'b0);
    bus.req_i = 4'b1000;
    wait_gnt(100);
    bus.req_i = '0;
    wait_valid(TO + 100, lat);
    chk("edge_latency", lat, TO + 1);
    wait_idle(100);
    chk("edge_no_flush", flush_cycles, 0);

    // Requester 1 job abandoned by reset during RUN
    mdl_delay = 0;
    gnt_q.push_back(4'b0010);
    terms_q.push_back(5'd7);
    bus.req_i = 4'b0010;
    wait_gnt(100);
    bus.req_i = '0;
    repeat (10) tick();
    chk("pre_reset_busy", bus.busy_o, 1);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk_reset();
    mdl_delay  = 5;
    mdl_result = 32'h0000_0077;
    flush_cycles = 0;
    push_job(4'b0001, 5'd3, 32'h77, 1'b0);
    tick();
    rst = 1'b0;
    bus.req_i = 4'b1111;
    @(negedge clk);
    chk("abandon_flush", bus.mac_flush_o, 1);
    chk("abandon_valid", bus.result_valid_o, 0);
    wait_gnt(100);
    bus.req_i = '0;
    chk("abandon_flush_off", bus.mac_flush_o, 0);
    wait_idle(100);
    chk("abandon_flush_cycles", flush_cycles, 1);
    chk("all_drained", exp_q.size() + gnt_q.size() + terms_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mac_scheduler.md
MAC_SCHEDULER -- requirements
Module: mac_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one mac instance.
REQ-002 Parameter DATA_WIDTH, default 32: signal and result word width.
REQ-003 Parameter ADDR_LINES, default 5: width of terms field.
REQ-004 Parameter TIMEOUT, default 1024: max cycles allowed from mac start to mac done.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 req_i  in  NUM_REQ  per-requester job request level, held until gnt_o seen.
REQ-008 req_terms_i  in  NUM_REQ*ADDR_LINES  per-requester term count, slice k = requester k.
REQ-009 req_signal_i  in  NUM_REQ*DATA_WIDTH  per-requester FIFO read data.
REQ-010 req_empty_i  in  NUM_REQ  per-requester FIFO empty.
REQ-011 req_rd_o  out  NUM_REQ  per-requester FIFO read enable.
REQ-012 gnt_o  out  NUM_REQ  one-hot grant, 1-cycle pulse.
REQ-013 mac_signal_o / mac_empty_o  out  DATA_WIDTH / 1  granted requester's FIFO data/empty to mac.
REQ-014 mac_rd_i  in  1  mac read strobe, routed to granted requester's req_rd_o.
REQ-015 mac_start_o  out  1  mac start (last) pulse; mac_terms_o  out  ADDR_LINES  terms to mac.
REQ-016 mac_result_i  in  DATA_WIDTH, mac_done_i  in  1  mac result and completion.
REQ-017 mac_flush_o  out  1  mac datapath/controller flush request.
REQ-018 result_o  out  DATA_WIDTH; result_valid_o  out  NUM_REQ one-hot; result_err_o  out  1; busy_o  out  1.

Function
REQ-019 FSM states SHALL be IDLE, START, RUN, DELIVER, FLUSH.
REQ-020 IDLE: if any req_i set, pick winner round-robin, pulse gnt_o[winner], latch winner index and its terms, go START; else stay.
REQ-021 Round-robin: search begins at (last_winner+1) mod NUM_REQ; last_winner resets to NUM_REQ-1 so requester 0 wins first tie.
REQ-022 START: mac_start_o=1 and mac_terms_o=latched terms for exactly one cycle; clear timeout counter; go RUN.
REQ-023 RUN: counter increments each cycle; mac_done_i=1 -> latch mac_result_i into result_o, go DELIVER; counter reaching TIMEOUT-1 without done -> go FLUSH.
REQ-024 mac_done_i and timeout in same cycle: done wins.
REQ-025 DELIVER: result_valid_o[winner]=1, result_err_o=0 for one cycle; go IDLE.
REQ-026 FLUSH: mac_flush_o=1 for exactly 2 cycles, result_valid_o[winner]=1 with result_err_o=1 and result_o=0 on second cycle; go IDLE.
REQ-027 mac_signal_o/mac_empty_o SHALL mux granted requester from START through RUN; elsewhere mac_signal_o=0, mac_empty_o=1.
REQ-028 req_rd_o[k] = mac_rd_i only when k is winner and state is START or RUN; all others 0.
REQ-029 busy_o=1 in every state except IDLE.
REQ-030 mac_done_i outside RUN SHALL be ignored.
REQ-031 Latched terms SHALL not change if req_terms_i changes after grant.
REQ-032 Earliest next grant: cycle after DELIVER/FLUSH exit (IDLE), so back-to-back jobs separated by one IDLE cycle.

Reset
REQ-033 rst_i high at a clock edge: state IDLE, last_winner=NUM_REQ-1, counter=0, result_o=0, all gnt_o/req_rd_o/result_valid_o/mac_start_o/mac_flush_o/result_err_o/busy_o=0, mac_terms_o=0, mac_empty_o=1.
REQ-034 Reset mid-job (any non-IDLE state) SHALL abandon job with no result_valid_o pulse and one cycle of mac_flush_o=1 on the first cycle after rst_i deasserts.

Verification
REQ-035 req_i=4'b0001, terms=3, mac_done after 20 cycles with result 0x3F800000 -> gnt_o=0001, one mac_start_o with mac_terms_o=3, result_valid_o=0001, result_o=0x3F800000, err=0.
REQ-036 req_i=4'b1111 held, each job done in 5 cycles -> grant order 0,1,2,3,0; no requester granted twice before others.
REQ-037 Granted requester 2, mac never asserts done -> FLUSH after 1024 cycles in RUN, mac_flush_o high 2 cycles, result_valid_o=0100 with err=1, result_o=0.
REQ-038 mac_done_i and timeout coincide on cycle 1023 -> DELIVER, err=0, no flush.
REQ-039 rst_i pulsed during RUN -> all outputs at reset values, no result_valid_o, one-cycle mac_flush_o after release, next request granted to requester 0.
REQ-040 During RUN for requester 1, mac_rd_i toggled -> only req_rd_o[1] follows; mac_signal_o tracks req_signal_i slice 1; stray mac_done_i in IDLE produces no output.
